// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART/ALU frame sequencer: state encoding,
// frame byte indices and the timeout counter width helper.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SEND = 3'd4
  } state_t;

  localparam int BYTE_A  = 0;
  localparam int BYTE_B  = 1;
  localparam int BYTE_OP = 2;

  // A counter of this width can hold every value up to t-1.
  function automatic int cnt_w(input int t);
    return (t <= 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// FIFO-side and ALU-side signal bundle of the frame sequencer.
// The ctrl modport is the sequencer; the peer modport is the UART/ALU side.
interface uart_alu_ctrl_if #(
  parameter int DBIT  = 8,
  parameter int NB_OP = 6
);
  logic             i_rx_empty;
  logic [DBIT-1:0]  i_r_data;
  logic             o_rd_uart;
  logic             i_tx_full;
  logic [DBIT-1:0]  o_w_data;
  logic             o_wr_uart;
  logic [DBIT-1:0]  o_alu_a;
  logic [DBIT-1:0]  o_alu_b;
  logic [NB_OP-1:0] o_alu_op;
  logic [DBIT-1:0]  i_alu_result;
  logic             o_busy;
  logic             o_timeout;

  modport ctrl (
    input  i_rx_empty, i_r_data, i_tx_full, i_alu_result,
    output o_rd_uart, o_w_data, o_wr_uart, o_alu_a, o_alu_b, o_alu_op,
           o_busy, o_timeout
  );

  modport peer (
    output i_rx_empty, i_r_data, i_tx_full, i_alu_result,
    input  o_rd_uart, o_w_data, o_wr_uart, o_alu_a, o_alu_b, o_alu_op,
           o_busy, o_timeout
  );
endinterface

// File: rtl/uart_ctrl_timer.sv
// Inter-byte timeout counter: clear has priority, enable counts up,
// expire flags the count reaching TIMEOUT-1.
module uart_ctrl_timer
  import uart_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = cnt_w(TIMEOUT);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expire = (count_q == W'(TIMEOUT - 1));
endmodule

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer: pops A, B, opcode from the UART rx FIFO, feeds the ALU,
// pushes the result byte to the tx FIFO. Optional inter-byte timeout is
// enabled with the UART_CTRL_TIMEOUT_EN macro.
module uart_alu_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int NB_OP   = 6,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  uart_alu_ctrl_if.ctrl bus
);
  state_t           state_q, state_d;
  logic [DBIT-1:0]  a_q, b_q, result_q;
  logic [NB_OP-1:0] op_q;
  logic             rd, wr, tmo, expire;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rd      = 1'b0;
    wr      = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      S_A: begin
        if (!bus.i_rx_empty) begin
          rd      = 1'b1;
          state_d = S_B;
        end
      end
      S_B: begin
        if (!bus.i_rx_empty) begin
          rd      = 1'b1;
          state_d = S_OP;
        end else if (expire) begin
          tmo     = 1'b1;
          state_d = S_A;
        end
      end
      S_OP: begin
        if (!bus.i_rx_empty) begin
          rd      = 1'b1;
          state_d = S_EXEC;
        end else if (expire) begin
          tmo     = 1'b1;
          state_d = S_A;
        end
      end
      S_EXEC: state_d = S_SEND;
      S_SEND: begin
        if (!bus.i_tx_full) begin
          wr      = 1'b1;
          state_d = S_A;
        end
      end
      default: state_d = S_A;
    endcase
  end

  // Operands are cleared by reset but otherwise only change on a pop.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      if (rd && state_q == S_A)  a_q  <= bus.i_r_data;
      if (rd && state_q == S_B)  b_q  <= bus.i_r_data;
      if (rd && state_q == S_OP) op_q <= bus.i_r_data[NB_OP-1:0];
      if (state_q == S_EXEC)     result_q <= bus.i_alu_result;
    end
  end

`ifdef UART_CTRL_TIMEOUT_EN
  logic waiting;
  assign waiting = (state_q == S_B) || (state_q == S_OP);

  uart_ctrl_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (i_clk),
    .rst_n  (i_reset),
    .clr    (rd || expire || !waiting),
    .en     (waiting && bus.i_rx_empty),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  assign bus.o_rd_uart = rd;
  assign bus.o_wr_uart = wr;
  assign bus.o_w_data  = result_q;
  assign bus.o_alu_a   = a_q;
  assign bus.o_alu_b   = b_q;
  assign bus.o_alu_op  = op_q;
  assign bus.o_busy    = (state_q != S_A);
  assign bus.o_timeout = tmo;
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench for uart_alu_ctrl: queue-modelled rx FIFO, behavioural ALU,
// expected tx bytes checked by an independent negedge monitor.
module tb_uart_alu_ctrl;
`ifdef UART_CTRL_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1_000_000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_alu_ctrl_if #(.DBIT(8), .NB_OP(6)) bus ();

  uart_alu_ctrl #(.DBIT(8), .NB_OP(6), .TIMEOUT(TMO)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int pop_cyc_q[$];
  int wr_cyc_q[$];
  int pop_cnt = 0, wr_cnt = 0, tmo_cnt = 0, last_tmo_cyc = 0, frames = 0;
  bit rand_full = 0;
  logic pop_now;

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  always_comb bus.i_alu_result = alu_model(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected bytes whenever the DUT pushes to the tx FIFO.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_rd_uart) begin
        check("rd_while_empty", {31'd0, bus.i_rx_empty}, 32'd0);
        pop_cnt++;
        pop_cyc_q.push_back(cyc);
      end
      if (bus.o_wr_uart) begin
        wr_cnt++;
        wr_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_wr", 32'd1, 32'd0);
        else check("w_data", {24'd0, bus.o_w_data}, {24'd0, exp_q.pop_front()});
      end
      if (bus.o_timeout) begin
        tmo_cnt++;
        last_tmo_cyc = cyc;
      end
    end
  end

  task automatic drive();
    bus.i_rx_empty = (rx_q.size() == 0);
    bus.i_r_data   = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  endtask

  task automatic tick();
    @(negedge clk);
    pop_now = bus.o_rd_uart;
    @(posedge clk);
    #1;
    if (pop_now && rx_q.size() != 0) void'(rx_q.pop_front());
    if (rand_full) bus.i_tx_full = ($urandom_range(0, 2) == 0);
    drive();
  endtask

  task automatic push(input logic [7:0] b);
    rx_q.push_back(b);
    drive();
  endtask

  task automatic expect_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    exp_q.push_back(alu_model(a, b, op[5:0]));
    frames++;
  endtask

  task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    push(a); push(b); push(op);
    expect_frame(a, b, op);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || rx_q.size() != 0 || bus.o_busy) && n < budget) begin
      tick();
      n++;
    end
    check("idle_within_budget", {31'd0, n < budget}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd"},   {31'd0, bus.o_rd_uart}, 32'd0);
    check({tag, "_wr"},   {31'd0, bus.o_wr_uart}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.o_busy}, 32'd0);
    check({tag, "_tmo"},  {31'd0, bus.o_timeout}, 32'd0);
    check({tag, "_abop"}, {8'd0, bus.o_alu_a, bus.o_alu_b, 2'd0, bus.o_alu_op}, 32'd0);
    check({tag, "_wdata"}, {24'd0, bus.o_w_data}, 32'd0);
  endtask

  initial begin
    int base, c, n;
    logic [7:0] a, b, op;
    bus.i_tx_full = 1'b0;
    drive();

    // Reset state
    repeat (2) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Basic ADD with pop/write timing
    pop_cyc_q.delete(); wr_cyc_q.delete();
    push_frame(8'h05, 8'h03, 8'h20);
    wait_idle(50);
    check("add_pops", pop_cyc_q.size(), 3);
    if (pop_cyc_q.size() == 3 && wr_cyc_q.size() == 1) begin
      check("add_pop_span", pop_cyc_q[2] - pop_cyc_q[0], 2);
      check("add_wr_lat", wr_cyc_q[0] - pop_cyc_q[2], 2);
    end else check("add_cycles_recorded", 32'd0, 32'd1);

    // Reset mid-frame
    push(8'h11); push(8'h22);
    tick(); tick();
    check("mid_a", {24'd0, bus.o_alu_a}, 32'h11);
    check("mid_b", {24'd0, bus.o_alu_b}, 32'h22);
    check("mid_busy", {31'd0, bus.o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    rst_n = 1'b1;
    push_frame(8'h01, 8'h02, 8'h20);
    wait_idle(50);

    // Starved input
    check("starve_busy_pre", {31'd0, bus.o_busy}, 32'd0);
    push(8'hF0); repeat (10) tick();
    check("starve_busy_1", {31'd0, bus.o_busy}, 32'd1);
    push(8'h0F); repeat (10) tick();
    check("starve_busy_2", {31'd0, bus.o_busy}, 32'd1);
    push(8'h24); expect_frame(8'hF0, 8'h0F, 8'h24);
    wait_idle(50);

    // TX backpressure with result 0xAA and the next frame already queued
    bus.i_tx_full = 1'b1;
    push_frame(8'hA0, 8'h0A, 8'h25);
    repeat (4) tick();
    push_frame(8'h01, 8'h01, 8'h20);
    base = pop_cnt; n = wr_cnt;
    repeat (20) tick();
    check("bp_no_pop", pop_cnt - base, 0);
    check("bp_no_wr", wr_cnt - n, 0);
    bus.i_tx_full = 1'b0;
    c = cyc;
    wr_cyc_q.delete();
    tick();
    check("bp_one_wr", wr_cnt - n, 1);
    if (wr_cyc_q.size() != 0) check("bp_wr_cycle", wr_cyc_q[0], c);
    else check("bp_wr_seen", 32'd0, 32'd1);
    wait_idle(50);

    // Back-to-back frames
    wr_cyc_q.delete();
    push_frame(8'h02, 8'h02, 8'h20);
    push_frame(8'h09, 8'h04, 8'h22);
    wait_idle(50);
    if (wr_cyc_q.size() == 2) check("b2b_spacing", wr_cyc_q[1] - wr_cyc_q[0], 5);
    else check("b2b_writes", wr_cyc_q.size(), 2);

`ifdef UART_CTRL_TIMEOUT_EN
    // Timeout after a lone byte
    pop_cyc_q.delete();
    base = tmo_cnt;
    push(8'h07);
    n = 0;
    while (tmo_cnt == base && n < 60) begin tick(); n++; end
    check("tmo_seen", tmo_cnt - base, 1);
    if (pop_cyc_q.size() != 0) check("tmo_delay", last_tmo_cyc - pop_cyc_q[0], 16);
    else check("tmo_pop_seen", 32'd0, 32'd1);
    check("tmo_busy", {31'd0, bus.o_busy}, 32'd0);
    check("tmo_a_kept", {24'd0, bus.o_alu_a}, 32'h07);
    push_frame(8'h01, 8'h01, 8'h20);
    wait_idle(50);
`endif

    // Randomized frames with random gaps and random tx backpressure
    rand_full = 1;
    for (int f = 0; f < 25; f++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = {2'($urandom), 6'h20 + 6'($urandom_range(0, 6))};
      push(a);  repeat ($urandom_range(0, 3)) tick();
      push(b);  repeat ($urandom_range(0, 3)) tick();
      push(op); expect_frame(a, b, op);
      repeat ($urandom_range(0, 6)) tick();
    end
    rand_full = 0;
    bus.i_tx_full = 1'b0;
    wait_idle(600);
    check("wr_total", wr_cnt, frames);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
